axis_pkt_tx: RTL and testbench
==============================

AXIS_PKT_TX -- requirements
Module: axis_pkt_tx

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles inserted after each packet's final beat; legal range 0..15.
REQ-002 Parameter DATA_W, default 8: stream data width in bits.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to send one packet.
REQ-006 pkt_len  input  8  beats in the requested packet, sampled with start; 0 is illegal.
REQ-007 seed  input  DATA_W  first data value of the packet, sampled with start.
REQ-008 m_data  output  DATA_W  stream data, registered.
REQ-009 m_valid  output  1  stream valid, registered.
REQ-010 m_ready  input  1  downstream ready; may toggle on any cycle.
REQ-011 m_last  output  1  marks the final beat of a packet, registered.
REQ-012 busy  output  1  high in SEND and GAP states.
REQ-013 done  output  1  one-cycle pulse, one cycle after the final beat's handshake.
REQ-014 err  output  1  one-cycle pulse when start is rejected for pkt_len = 0.
REQ-015 pkt_count  output  16  count of packets fully sent since reset; wraps at 65535 -> 0.

Function
REQ-016 The block SHALL implement FSM states IDLE, SEND and GAP.
REQ-017 IDLE -> SEND: start=1 and pkt_len!=0; pkt_len and seed latched; m_valid=1 in the next cycle.
REQ-018 start with pkt_len=0 in IDLE: remain IDLE, err=1 in the next cycle, no beat emitted.
REQ-019 start while busy=1: ignored, no err, latched values unchanged.
REQ-020 Handshake occurs on a cycle with m_valid=1 and m_ready=1.
REQ-021 Beat i (0-based) SHALL carry m_data = (seed + i) mod 2^DATA_W, wrapping silently.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_valid and m_last SHALL hold stable.
REQ-023 m_valid SHALL NOT depend combinationally on m_ready.
REQ-024 After a non-final handshake, the next beat is presented in the following cycle: one beat per cycle under continuous m_ready.
REQ-025 m_last=1 only on beat pkt_len-1; pkt_len=1 gives a single beat with m_last=1.
REQ-026 Final-beat handshake: next cycle m_valid=0, m_last=0, done=1, pkt_count increments.
REQ-027 Final-beat handshake transitions to GAP when GAP_CYCLES>0, otherwise directly to IDLE.
REQ-028 GAP: m_valid=0 for exactly GAP_CYCLES cycles, then IDLE; start is ignored during GAP.
REQ-029 With GAP_CYCLES=0, start may be accepted in the done cycle, giving back-to-back packets with a single idle cycle between them.
REQ-030 The beat counter SHALL be 8 bits; it compares against the latched pkt_len, never the live input.

Reset
REQ-031 While rst=1 at a clock edge, all outputs SHALL be 0 at the next edge: m_data, m_valid, m_last, busy, done, err, pkt_count.
REQ-032 Reset SHALL return the FSM to IDLE and clear the beat counter, gap counter and latched registers.
REQ-033 Reset mid-packet: m_valid drops at the next edge, the packet is abandoned, pkt_count=0, and no done pulse is issued.
REQ-034 rst takes priority over start and m_ready in the same cycle.

Structure
REQ-035 Shared package axis_tx_pkg SHALL hold the FSM state encoding (2-bit), the GAP_CYCLES default and the DATA_W default.
REQ-036 The design SHALL be a single module with one natural sub-module, axis_beat_ctr: beat counter plus last-beat compare.
REQ-037 RTL SHALL be synthesizable with no latches, and every output SHALL be driven from a flop.

Verification
REQ-038 Basic packet: seed=0x10, pkt_len=4, m_ready=1 -> data 10,11,12,13 on consecutive cycles, m_last on 0x13, done one cycle later, pkt_count=1.
REQ-039 Backpressure: pkt_len=3, m_ready pattern 1,0,0,1,1 -> beats stable during stalls, 3 handshakes, m_last only on the third.
REQ-040 Wrap: seed=0xFE, pkt_len=4 -> data FE,FF,00,01.
REQ-041 Illegal and overlapping start: pkt_len=0 -> err pulse with no m_valid; start during SEND -> ignored, original packet completes unchanged.
REQ-042 Gap: GAP_CYCLES=2 with start held high -> exactly 2 gap cycles plus 1 IDLE cycle between the final beat and the next first beat.
REQ-043 Reset mid-packet: rst at beat 2 of 5 -> m_valid=0 at the next edge, pkt_count=0, no done pulse.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// Shared definitions for the packet transmitter: FSM encoding and parameter defaults.
package axis_tx_pkg;

    localparam int unsigned DEF_GAP_CYCLES = 2;
    localparam int unsigned DEF_DATA_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/axis_beat_ctr.sv
// Beat counter for one packet plus the "is the presented beat the last one" compare.
module axis_beat_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_len,
    input  logic       inc,
    output logic       last_next
);

    logic [7:0] cnt;
    logic [7:0] len_q;

    // Count beats of the current packet against the length latched at load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= load_len;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Last-beat flag for the beat that will be presented after this edge.
    always_comb begin
        last_next = 1'b0;
        if (load) begin
            last_next = (load_len == 8'd1);
        end else if (inc) begin
            last_next = ((cnt + 8'd1) == (len_q - 8'd1));
        end else begin
            last_next = (cnt == (len_q - 8'd1));
        end
    end

endmodule

// File: rtl/axis_pkt_tx.sv
// AXI-Stream style packet generator: incrementing data from a seed, with inter-packet gap.
module axis_pkt_tx
    import axis_tx_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pkt_len,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       pkt_count
);

    localparam logic [3:0] GAP_RELOAD = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    tx_state_t         state, state_nx;
    logic [3:0]        gap_q, gap_nx;
    logic [DATA_W-1:0] data_nx;
    logic              valid_nx, last_nx, busy_nx, done_nx, err_nx;
    logic [15:0]       count_nx;
    logic              ctr_load, ctr_inc, ctr_last_next;

    axis_beat_ctr u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_len  (pkt_len),
        .inc       (ctr_inc),
        .last_next (ctr_last_next)
    );

    // State and all output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_q     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pkt_count <= '0;
        end else begin
            state     <= state_nx;
            gap_q     <= gap_nx;
            m_data    <= data_nx;
            m_valid   <= valid_nx;
            m_last    <= last_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
            pkt_count <= count_nx;
        end
    end

    // Next-state and next-output decode; m_valid never looks at m_ready combinationally.
    always_comb begin
        state_nx = state;
        gap_nx   = gap_q;
        data_nx  = m_data;
        valid_nx = m_valid;
        last_nx  = m_last;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        count_nx = pkt_count;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (pkt_len != 8'd0) begin
                        state_nx = ST_SEND;
                        ctr_load = 1'b1;
                        data_nx  = seed;
                        valid_nx = 1'b1;
                        last_nx  = ctr_last_next;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (m_valid && m_ready) begin
                    if (m_last) begin
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                        done_nx  = 1'b1;
                        count_nx = pkt_count + 16'd1;
                        if (GAP_CYCLES != 0) begin
                            state_nx = ST_GAP;
                            gap_nx   = GAP_RELOAD;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        ctr_inc = 1'b1;
                        data_nx = m_data + DATA_W'(1);
                        last_nx = ctr_last_next;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_nx = ST_IDLE;
                end else begin
                    gap_nx = gap_q - 4'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// Self-checking bench for axis_pkt_tx: directed scenarios plus randomized traffic
// against a packet-level reference model.
module tb_axis_pkt_tx;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pkt_len = '0;
    logic [7:0]  seed = '0;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, m_last, busy, done, err;
    logic [15:0] pkt_count;

    // Second instance with no gap, used for the back-to-back case.
    logic        start0 = 1'b0;
    logic [7:0]  len0 = '0;
    logic [7:0]  seed0 = '0;
    logic        ready0 = 1'b1;
    logic [7:0]  data0;
    logic        valid0, last0, busy0, done0, err0;
    logic [15:0] count0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axis_pkt_tx #(.GAP_CYCLES(GAP), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .seed(seed),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .err(err), .pkt_count(pkt_count)
    );

    axis_pkt_tx #(.GAP_CYCLES(0), .DATA_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pkt_len(len0), .seed(seed0),
        .m_data(data0), .m_valid(valid0), .m_ready(ready0), .m_last(last0),
        .busy(busy0), .done(done0), .err(err0), .pkt_count(count0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: packet-level view (phase, beat index, remaining gap)
    int          ph = 0;        // 0 idle, 1 sending, 2 gap
    int          e_idx = 0;
    int          e_len = 0;
    logic [7:0]  e_seed = '0;
    int          e_gap = 0;
    bit          e_valid = 0, e_done = 0, e_err = 0, e_busy = 0;
    int          e_count = 0;
    bit          mon_en = 0;

    // Monitor side records
    logic [7:0]  hs_data[$];
    bit          hs_last[$];
    int          cyc_n = 0;
    int          last_hs_cyc = 0;
    int          first_cyc = 0;
    int          n_rise = 0;
    bit          prev_valid = 0;

    // Compare DUT against the model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        cyc_n++;
        if (mon_en) begin
            check("valid", 32'(m_valid), 32'(e_valid));
            if (e_valid) check("data", 32'(m_data), 32'(8'(e_seed + 8'(e_idx))));
            check("last", 32'(m_last), 32'(e_valid && (e_idx == e_len - 1)));
            check("done", 32'(done), 32'(e_done));
            check("err", 32'(err), 32'(e_err));
            check("busy", 32'(busy), 32'(e_busy));
            check("pkt_count", 32'(pkt_count), 32'(16'(e_count)));
            if (m_valid && m_ready) begin
                hs_data.push_back(m_data);
                hs_last.push_back(m_last);
                if (m_last) last_hs_cyc = cyc_n;
            end
            if (m_valid && !prev_valid) begin
                first_cyc = cyc_n;
                n_rise++;
            end
        end
        prev_valid = m_valid;

        e_done = 0;
        e_err  = 0;
        if (rst) begin
            ph = 0; e_valid = 0; e_count = 0; e_idx = 0; e_len = 0;
        end else if (ph == 1) begin
            if (m_ready) begin
                if (e_idx == e_len - 1) begin
                    e_valid = 0;
                    e_done  = 1;
                    e_count = (e_count + 1) % 65536;
                    if (GAP > 0) begin
                        ph = 2; e_gap = GAP;
                    end else begin
                        ph = 0;
                    end
                end else begin
                    e_idx++;
                end
            end
        end else if (ph == 2) begin
            e_gap--;
            if (e_gap == 0) ph = 0;
        end else begin
            if (start) begin
                if (pkt_len != 0) begin
                    ph = 1; e_idx = 0; e_len = int'(pkt_len); e_seed = seed; e_valid = 1;
                end else begin
                    e_err = 1;
                end
            end
        end
        e_busy = (ph != 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] len, input logic [7:0] sd);
        start = 1'b1; pkt_len = len; seed = sd;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1;
            else cyc();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic settle();
        repeat (5) cyc();
    endtask

    initial begin
        int v_pat[7] = '{0, 1, 1, 0, 1, 1, 0};
        int d_pat[7] = '{0, 0, 0, 1, 0, 0, 1};
        int x_pat[7] = '{0, 'h30, 'h31, 0, 'h30, 'h31, 0};
        int r_pat[5] = '{1, 0, 0, 1, 1};
        int base;

        // Reset state
        repeat (3) cyc();
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        mon_en = 1;
        rst = 1'b0;
        m_ready = 1'b1;
        cyc();

        // Basic packet
        hs_data.delete(); hs_last.delete();
        send(8'd4, 8'h10);
        wait_done("basic_done_timeout");
        check("basic_beats", 32'(hs_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_data.size(); i++)
            check("basic_data", 32'(hs_data[i]), 32'('h10 + i));
        check("basic_last", 32'(hs_last.size() == 4 && hs_last[3] && !hs_last[2]), 32'd1);
        check("basic_count", 32'(pkt_count), 32'd1);
        settle();

        // Backpressure
        hs_data.delete(); hs_last.delete();
        send(8'd3, 8'h70);
        for (int i = 0; i < 5; i++) begin
            m_ready = r_pat[i][0];
            cyc();
        end
        m_ready = 1'b1;
        check("bp_done", 32'(done), 32'd1);
        check("bp_beats", 32'(hs_data.size()), 32'd3);
        if (hs_last.size() == 3)
            check("bp_last", {29'd0, hs_last[0], hs_last[1], hs_last[2]}, 32'b001);
        settle();

        // Wrap
        hs_data.delete();
        send(8'd4, 8'hFE);
        wait_done("wrap_done_timeout");
        if (hs_data.size() == 4)
            check("wrap_data", {hs_data[0], hs_data[1], hs_data[2], hs_data[3]}, 32'hFEFF0001);
        else
            check("wrap_beats", 32'(hs_data.size()), 32'd4);
        settle();

        // Illegal length
        send(8'd0, 8'h33);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_valid", 32'(m_valid), 32'd0);
        cyc();
        check("illegal_err_clear", 32'(err), 32'd0);
        settle();

        // Start while busy is ignored
        hs_data.delete();
        send(8'd5, 8'h40);
        start = 1'b1; pkt_len = 8'd2; seed = 8'h99;
        repeat (2) cyc();
        start = 1'b0;
        wait_done("overlap_done_timeout");
        check("overlap_beats", 32'(hs_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < hs_data.size(); i++)
            check("overlap_data", 32'(hs_data[i]), 32'('h40 + i));
        settle();

        // Gap spacing with start held high
        base = n_rise;
        start = 1'b1; pkt_len = 8'd2; seed = 8'h20;
        for (int i = 0; i < 40 && n_rise < base + 2; i++) cyc();
        start = 1'b0;
        check("gap_spacing", 32'(first_cyc - last_hs_cyc), 32'd4);
        wait_done("gap_done_timeout");
        settle();

        // Reset mid-packet at beat 2 of 5
        send(8'd5, 8'h50);
        repeat (2) cyc();
        check("mid_beat2", 32'(m_data), 32'h52);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_valid", 32'(m_valid), 32'd0);
        check("mid_count", 32'(pkt_count), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        cyc();
        check("mid_no_done", 32'(done), 32'd0);
        settle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 249) == 0);
            start   = ($urandom_range(0, 3) == 0);
            pkt_len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            seed    = 8'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst = 1'b0; start = 1'b0; m_ready = 1'b1;
        repeat (20) cyc();

        // Back-to-back packets with no gap configured
        start0 = 1'b1; len0 = 8'd2; seed0 = 8'h30;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("b2b_valid", 32'(valid0), 32'(v_pat[i]));
            check("b2b_done", 32'(done0), 32'(d_pat[i]));
            if (v_pat[i] != 0) check("b2b_data", 32'(data0), 32'(x_pat[i]));
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (6) cyc();
        check("b2b_idle", 32'(valid0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
